tl_d_resp_arbiter: RTL and testbench



---
 rtl/tl_d_resp_arbiter_pkg.sv | 33 +++
 rtl/tl_d_resp_arbiter_if.sv | 25 ++
 rtl/tl_d_resp_arbiter_rr_pick.sv | 27 ++
 rtl/tl_d_resp_arbiter.sv | 141 ++++++++++++++
 tb/tb_tl_d_resp_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/tl_d_resp_arbiter_pkg.sv
// Shared types for the TileLink-UL D-channel response arbiter: payload struct,
// opcodes, arbiter states and the burst beat-count helper.
package tl_d_resp_arbiter_pkg;

  localparam int unsigned BUS_BYTES_LOG2 = 2;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [7:0]  source;
    logic        sink;
    logic [31:0] data;
    logic        error;
  } tl_d_channel;

  typedef enum logic [0:0] {StIdle, StBurst} arb_state_e;

  // Beats in a response; sizes beyond 16 beats clamp to the beat counter's range.
  function automatic logic [4:0] tl_beats(input logic [2:0] opcode, input logic [3:0] size);
    logic [4:0] beats;
    beats = 5'd1;
    if (opcode == ACCESS_ACK_DATA && size > 4'(BUS_BYTES_LOG2)) begin
      if (size >= 4'd6) beats = 5'd16;
      else              beats = 5'd1 << (size - 4'(BUS_BYTES_LOG2));
    end
    return beats;
  endfunction

endpackage

// File: rtl/tl_d_resp_arbiter_if.sv
// FIFO-side and D-channel signals of the response arbiter; master = arbiter side.
interface tl_d_resp_arbiter_if
  import tl_d_resp_arbiter_pkg::*;
#(
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned PORT_BITS = 1
);
  logic [N_PORTS-1:0]   fifo_valid;
  logic [N_PORTS-1:0]   fifo_deq;
  tl_d_channel          fifo_data [N_PORTS];
  logic                 d_valid;
  logic                 d_ready;
  tl_d_channel          d_bits;
  logic [PORT_BITS-1:0] grant_port;

  modport master (
    input  fifo_valid, fifo_data, d_ready,
    output fifo_deq, d_valid, d_bits, grant_port
  );

  modport slave (
    output fifo_valid, fifo_data, d_ready,
    input  fifo_deq, d_valid, d_bits, grant_port
  );
endinterface

// File: rtl/tl_d_resp_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid port at or after ptr, wrapping.
module tl_d_resp_arbiter_rr_pick #(
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned PORT_BITS = 1
) (
  input  logic [N_PORTS-1:0]   valid,
  input  logic [PORT_BITS-1:0] ptr,
  output logic [N_PORTS-1:0]   onehot,
  output logic [PORT_BITS-1:0] idx,
  output logic                 any
);
  always_comb begin
    int unsigned p;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    p      = 0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      p = (32'(ptr) + k) % N_PORTS;
      if (!any && valid[p]) begin
        any       = 1'b1;
        onehot[p] = 1'b1;
        idx       = PORT_BITS'(p);
      end
    end
  end
endmodule

// File: rtl/tl_d_resp_arbiter.sv
// Round-robin merge of N response FIFOs onto one registered TL-UL D channel, with
// burst lock for multi-beat AccessAckData. `D_ARB_STATS_EN adds stall/burst counters.
module tl_d_resp_arbiter
  import tl_d_resp_arbiter_pkg::*;
#(
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned PORT_BITS = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  parameter int unsigned BEAT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef D_ARB_STATS_EN
  output logic [31:0]         stall_cnt,
  output logic [31:0]         burst_cnt,
`endif
  tl_d_resp_arbiter_if.master bus
);
  arb_state_e           state_q, state_d;
  logic [PORT_BITS-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, sel;
  logic [BEAT_BITS-1:0] beats_left_q, beats_left_d;
  logic                 d_valid_q, d_valid_d, slot_free, pop;
  tl_d_channel          d_bits_q, d_bits_d;
  logic [N_PORTS-1:0]   deq, pick_onehot;
  logic [PORT_BITS-1:0] pick_idx;
  logic                 pick_any;
  logic [4:0]           beats;

  function automatic logic [PORT_BITS-1:0] next_port(input logic [PORT_BITS-1:0] p);
    return (32'(p) == N_PORTS - 1) ? '0 : p + 1'b1;
  endfunction

  tl_d_resp_arbiter_rr_pick #(
    .N_PORTS  (N_PORTS),
    .PORT_BITS(PORT_BITS)
  ) u_rr_pick (
    .valid (bus.fifo_valid),
    .ptr   (rr_ptr_q),
    .onehot(pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    beats_left_d = beats_left_q;
    d_valid_d    = d_valid_q;
    d_bits_d     = d_bits_q;
    deq          = '0;
    sel          = pick_idx;
    pop          = 1'b0;
    beats        = 5'd1;
    slot_free    = !d_valid_q || bus.d_ready;

    case (state_q)
      StIdle: begin
        pop = slot_free && pick_any;
        if (pop) deq = pick_onehot;
      end
      StBurst: begin
        // Burst owner only; an empty owner stalls the channel rather than yielding.
        sel = grant_q;
        pop = slot_free && bus.fifo_valid[grant_q];
        if (pop) deq[grant_q] = 1'b1;
      end
      default: ;
    endcase

    if (pop) begin
      d_bits_d  = bus.fifo_data[sel];
      d_valid_d = 1'b1;
      beats     = tl_beats(d_bits_d.opcode, d_bits_d.size);
      if (state_q == StIdle) begin
        grant_d = sel;
        if (beats > 5'd1) begin
          beats_left_d = BEAT_BITS'(beats - 5'd1);
          state_d      = StBurst;
        end else begin
          rr_ptr_d = next_port(sel);
        end
      end else begin
        beats_left_d = beats_left_q - 1'b1;
        if (beats_left_q == BEAT_BITS'(1)) begin
          state_d  = StIdle;
          rr_ptr_d = next_port(grant_q);
        end
      end
    end else if (bus.d_ready) begin
      d_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      beats_left_q <= '0;
      d_valid_q    <= 1'b0;
      d_bits_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      beats_left_q <= beats_left_d;
      d_valid_q    <= d_valid_d;
      d_bits_q     <= d_bits_d;
    end
  end

  assign bus.fifo_deq   = deq;
  assign bus.d_valid    = d_valid_q;
  assign bus.d_bits     = d_bits_q;
  assign bus.grant_port = grant_q;

`ifdef D_ARB_STATS_EN
  logic [31:0] stall_q, burst_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      burst_q <= '0;
    end else begin
      if (d_valid_q && !bus.d_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (state_q == StIdle && state_d == StBurst && burst_q != '1) burst_q <= burst_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign burst_cnt = burst_q;
`endif

`ifndef SYNTHESIS
  a_deq_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.fifo_deq));
  a_deq_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.fifo_deq & ~bus.fifo_valid) == '0);
  a_bits_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (d_valid_q && !bus.d_ready) |=> $stable(d_bits_q));
`endif
endmodule

// File: tb/tb_tl_d_resp_arbiter.sv
// Self-checking bench: queue-based FIFO/arbitration model, directed and random traffic.
module tb_tl_d_resp_arbiter;
  import tl_d_resp_arbiter_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef D_ARB_STATS_EN
  logic [31:0] stall_cnt, burst_cnt;
`endif

  tl_d_resp_arbiter_if #(.N_PORTS(N), .PORT_BITS(1)) bus ();

  tl_d_resp_arbiter #(.N_PORTS(N), .PORT_BITS(1), .BEAT_BITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef D_ARB_STATS_EN
    .stall_cnt(stall_cnt),
    .burst_cnt(burst_cnt),
`endif
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  tl_d_channel q [N][$];
  // Model of the output slot and arbitration bookkeeping.
  bit          m_valid;
  tl_d_channel m_bits;
  int          m_grant, m_ptr, m_lock, m_left;
  longint      m_stall, m_burst;
  longint      log_code;
  int          log_n, cyc, first_pop, last_pop;
  bit          ready_cfg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_beats(input tl_d_channel t);
    if (t.opcode == 3'd1 && t.size > 4'd2) return 2 ** (int'(t.size) - 2);
    return 1;
  endfunction

  task automatic push(input int p, input logic [2:0] op, input logic [3:0] sz,
                      input logic [31:0] data);
    tl_d_channel t;
    t = '0;
    t.opcode = op;
    t.size   = sz;
    t.source = 8'(p);
    t.data   = data;
    q[p].push_back(t);
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      bus.fifo_valid[p] = q[p].size() > 0;
      bus.fifo_data[p]  = (q[p].size() > 0) ? q[p][0] : '0;
    end
    bus.d_ready = ready_cfg;
  endtask

  task automatic step();
    int sel, p;
    bit slot_free;
    logic [N-1:0] exp_deq;
    tl_d_channel t;
    @(negedge clk);
    drive();
    #1;
    cyc++;
    slot_free = !m_valid || ready_cfg;
    sel = -1;
    if (m_lock >= 0) begin
      if (q[m_lock].size() > 0) sel = m_lock;
    end else begin
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (sel < 0 && q[p].size() > 0) sel = p;
      end
    end
    if (!slot_free) sel = -1;
    exp_deq = '0;
    if (sel >= 0) exp_deq[sel] = 1'b1;
    chk("fifo_deq", 64'(bus.fifo_deq), 64'(exp_deq));
    chk("d_valid", 64'(bus.d_valid), 64'(m_valid));
    chk("grant_port", 64'(bus.grant_port), 64'(m_grant));
    if (m_valid) chk("d_bits", 64'(bus.d_bits), 64'(m_bits));
`ifdef D_ARB_STATS_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("burst_cnt", 64'(burst_cnt), 64'(m_burst));
`endif
    if (m_valid && !ready_cfg) m_stall++;
    if (sel >= 0) begin
      t = q[sel].pop_front();
      m_bits  = t;
      m_valid = 1'b1;
      log_code = log_code * 10 + sel + 1;
      log_n++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (m_lock < 0) begin
        m_grant = sel;
        if (model_beats(t) > 1) begin
          m_lock = sel;
          m_left = model_beats(t) - 1;
          m_burst++;
        end else begin
          m_ptr = (sel + 1) % N;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_lock = -1;
          m_ptr  = (sel + 1) % N;
        end
      end
    end else if (ready_cfg) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int p = 0; p < N; p++) q[p].delete();
    ready_cfg = 1'b1;
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0; m_bits = '0; m_grant = 0; m_ptr = 0; m_lock = -1; m_left = 0;
    m_stall = 0; m_burst = 0; log_code = 0; log_n = 0; first_pop = -1; last_pop = -1;
    #1;
    chk("rst d_valid", 64'(bus.d_valid), 64'd0);
    chk("rst grant_port", 64'(bus.grant_port), 64'd0);
    chk("rst fifo_deq", 64'(bus.fifo_deq), 64'd0);
    chk("rst d_bits", 64'(bus.d_bits), 64'd0);
`ifdef D_ARB_STATS_EN
    chk("rst stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst burst_cnt", 64'(burst_cnt), 64'd0);
`endif
  endtask

  initial begin
    cyc = 0;
    ready_cfg = 1'b1;
    drive();

    // Single port, three single-beat acks back to back.
    do_reset();
    for (int i = 0; i < 3; i++) push(0, ACCESS_ACK, 4'd2, 32'h100 + 32'(i));
    repeat (5) step();
    chk("t1 pop order", 64'(log_code), 64'd111);
    chk("t1 consecutive", 64'(last_pop - first_pop), 64'd2);

    // Two always-valid ports alternate.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(0, ACCESS_ACK, 4'd0, 32'h200 + 32'(i));
      push(1, ACCESS_ACK_DATA, 4'd2, 32'h300 + 32'(i));
    end
    repeat (10) step();
    chk("t2 alternation", 64'(log_code), 64'd12121212);

    // Four-beat burst on port 0 holds the grant over a waiting port 1.
    do_reset();
    for (int i = 0; i < 4; i++) push(0, ACCESS_ACK_DATA, 4'd4, 32'h400 + 32'(i));
    push(1, ACCESS_ACK, 4'd0, 32'h500);
    repeat (7) step();
    chk("t3 burst lock", 64'(log_code), 64'd11112);

    // Back-pressure: payload held, no pops, pop resumes as ready returns.
    do_reset();
    for (int i = 0; i < 3; i++) push(0, ACCESS_ACK, 4'd0, 32'hA0 + 32'(i));
    step();
    ready_cfg = 1'b0;
    repeat (5) step();
    chk("t4 no pop stalled", 64'(log_n), 64'd1);
    chk("t4 held data", 64'(bus.d_bits.data), 64'hA0);
    ready_cfg = 1'b1;
    step();
    chk("t4 pop on ready", 64'(log_n), 64'd2);
    repeat (3) step();

    // Owner FIFO runs dry mid-burst; port 1 starves until the burst completes.
    do_reset();
    push(0, ACCESS_ACK_DATA, 4'd4, 32'h600);
    push(0, ACCESS_ACK_DATA, 4'd4, 32'h601);
    push(1, ACCESS_ACK, 4'd0, 32'h700);
    repeat (6) step();
    chk("t5 starve", 64'(log_code), 64'd11);
    chk("t5 grant held", 64'(bus.grant_port), 64'd0);
    push(0, ACCESS_ACK_DATA, 4'd4, 32'h602);
    push(0, ACCESS_ACK_DATA, 4'd4, 32'h603);
    repeat (6) step();
    chk("t5 resume", 64'(log_code), 64'd11112);

    // Reset in the middle of an eight-beat burst on port 1.
    do_reset();
    for (int i = 0; i < 8; i++) push(1, ACCESS_ACK_DATA, 4'd5, 32'h800 + 32'(i));
    repeat (3) step();
    chk("t6 pre-reset grant", 64'(bus.grant_port), 64'd1);
    chk("t6 pre-reset pops", 64'(log_code), 64'd222);
    do_reset();
    repeat (3) step();

    // Random traffic with random back-pressure.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 2) == 0 && q[p].size() < 8)
          push(p, 3'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), $urandom);
      end
      ready_cfg = $urandom_range(0, 3) != 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
